svf_filter: RTL and testbench



---
 rtl/svf_filter.sv | 153 +++++++++++++++
 tb/tb_svf_filter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/svf_filter.sv
// svf_filter: sample-strobe divider, F/Q1 coefficient ROMs and a Chamberlin state-variable filter.
// Define SVF_SATURATE_EN to clamp filter state and outputs instead of wrapping.
module svf_filter #(
  parameter int SAMPLE_BITS = 12,
  parameter int CLK_HZ      = 16000000,
  parameter int SAMPLE_RATE = 44100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SAMPLE_BITS-1:0] in,
  input  logic        [6:0]             freq,
  input  logic        [6:0]             q,
  input  logic        [3:0]             sel,
  output logic                          sample_stb,
  output logic signed [SAMPLE_BITS-1:0] out_lp,
  output logic signed [SAMPLE_BITS-1:0] out_hp,
  output logic signed [SAMPLE_BITS-1:0] out_bp,
  output logic signed [SAMPLE_BITS-1:0] out_notch,
  output logic signed [SAMPLE_BITS-1:0] audio_out
);

  localparam int  DIVISOR = CLK_HZ / SAMPLE_RATE;
  localparam int  CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int  SW      = SAMPLE_BITS + 4;
  localparam int  CB      = 18;
  localparam int  EW      = SW + CB;
  localparam real PI      = 3.141592653589793;

  function automatic logic [128*CB-1:0] build_f_rom();
    real fc;
    real w;
    build_f_rom = '0;
    for (int v = 0; v < 128; v++) begin
      fc = 440.0 * (2.0 ** ((real'(v) - 69.0) / 12.0));
      w  = 2.0 * $sin(PI * fc / real'(SAMPLE_RATE)) * 65536.0;
      build_f_rom[v*CB +: CB] = CB'($rtoi(w + 0.5));
    end
  endfunction

  function automatic logic [128*CB-1:0] build_q1_rom();
    build_q1_rom = '0;
    for (int v = 0; v < 128; v++) begin
      build_q1_rom[v*CB +: CB] = CB'(131071 - 960 * v);
    end
  endfunction

  localparam logic [128*CB-1:0] F_ROM  = build_f_rom();
  localparam logic [128*CB-1:0] Q1_ROM = build_q1_rom();

`ifdef SVF_SATURATE_EN
  localparam logic signed [EW-1:0] ST_MAX  = EW'((2 ** (SW - 1)) - 1);
  localparam logic signed [EW-1:0] ST_MIN  = -ST_MAX - 1;
  localparam logic signed [EW-1:0] OUT_MAX = EW'((2 ** (SAMPLE_BITS - 1)) - 1);
  localparam logic signed [EW-1:0] OUT_MIN = -OUT_MAX - 1;

  function automatic logic signed [EW-1:0] mul_full(input logic signed [CB-1:0] c,
                                                    input logic signed [SW-1:0] s);
    mul_full = (EW'(c) * EW'(s)) >>> 16;
  endfunction

  function automatic logic signed [SW-1:0] sat_state(input logic signed [EW-1:0] x);
    if (x > ST_MAX)      sat_state = SW'(ST_MAX);
    else if (x < ST_MIN) sat_state = SW'(ST_MIN);
    else                 sat_state = SW'(x);
  endfunction

  function automatic logic signed [SAMPLE_BITS-1:0] sat_out(input logic signed [EW-1:0] x);
    if (x > OUT_MAX)      sat_out = SAMPLE_BITS'(OUT_MAX);
    else if (x < OUT_MIN) sat_out = SAMPLE_BITS'(OUT_MIN);
    else                  sat_out = SAMPLE_BITS'(x);
  endfunction
`else
  // Truncating the shifted product before the add is exact under modulo-2^SW wrap.
  function automatic logic signed [SW-1:0] mul_wrap(input logic signed [CB-1:0] c,
                                                    input logic signed [SW-1:0] s);
    mul_wrap = SW'((EW'(c) * EW'(s)) >>> 16);
  endfunction
`endif

  logic        [CW-1:0]          cnt_q, cnt_d;
  logic signed [SW-1:0]          lo_q, lo_d, hi_q, hi_d, bp_q, bp_d;
  logic signed [SAMPLE_BITS-1:0] in_q, in_d;
  logic signed [CB-1:0]          f_q, f_d, q1_q, q1_d;

  assign sample_stb = (cnt_q == CW'(DIVISOR - 1));

  always_comb begin
    cnt_d = sample_stb ? '0 : cnt_q + 1'b1;
    lo_d  = lo_q;
    hi_d  = hi_q;
    bp_d  = bp_q;
    in_d  = in_q;
    f_d   = f_q;
    q1_d  = q1_q;
    if (sample_stb) begin
      // The step uses the coefficients loaded on the previous strobe.
`ifdef SVF_SATURATE_EN
      lo_d = sat_state(EW'(lo_q) + mul_full(f_q, bp_q));
      hi_d = sat_state(EW'(in) - EW'(lo_d) - mul_full(q1_q, bp_q));
      bp_d = sat_state(EW'(bp_q) + mul_full(f_q, hi_d));
`else
      lo_d = lo_q + mul_wrap(f_q, bp_q);
      hi_d = SW'(in) - lo_d - mul_wrap(q1_q, bp_q);
      bp_d = bp_q + mul_wrap(f_q, hi_d);
`endif
      in_d = in;
      f_d  = F_ROM[int'(freq) * CB +: CB];
      q1_d = Q1_ROM[int'(q) * CB +: CB];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      bp_q  <= '0;
      in_q  <= '0;
      f_q   <= F_ROM[CB-1:0];
      q1_q  <= Q1_ROM[CB-1:0];
    end else begin
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      bp_q  <= bp_d;
      in_q  <= in_d;
      f_q   <= f_d;
      q1_q  <= q1_d;
    end
  end

  // Outputs are the post-strobe state narrowed to the sample width, so they hold between strobes.
`ifdef SVF_SATURATE_EN
  assign out_lp    = sat_out(EW'(lo_q));
  assign out_hp    = sat_out(EW'(hi_q));
  assign out_bp    = sat_out(EW'(bp_q));
  assign out_notch = sat_out(EW'(hi_q) + EW'(lo_q));
`else
  assign out_lp    = SAMPLE_BITS'(lo_q);
  assign out_hp    = SAMPLE_BITS'(hi_q);
  assign out_bp    = SAMPLE_BITS'(bp_q);
  assign out_notch = SAMPLE_BITS'(hi_q + lo_q);
`endif

  always_comb begin
    audio_out = out_notch;
    if (sel == 4'd0)       audio_out = in_q;
    else if (sel <= 4'd4)  audio_out = out_lp;
    else if (sel <= 4'd8)  audio_out = out_hp;
    else if (sel <= 4'd12) audio_out = out_bp;
  end

endmodule

// File: tb/tb_svf_filter.sv
// Scoreboard bench for svf_filter: a behavioural model pushes expected outputs at each strobe,
// the monitor pops and compares them on the following cycle.
module tb_svf_filter;

  localparam int SB  = 12;
  localparam int SW  = SB + 4;
  localparam int DIV = 362;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SB-1:0] in_s = '0;
  logic        [6:0]    freq = '0;
  logic        [6:0]    q = '0;
  logic        [3:0]    sel = '0;
  logic                 sample_stb;
  logic signed [SB-1:0] out_lp, out_hp, out_bp, out_notch, audio_out;

  svf_filter dut (
    .clk(clk), .rst(rst), .in(in_s), .freq(freq), .q(q), .sel(sel),
    .sample_stb(sample_stb), .out_lp(out_lp), .out_hp(out_hp), .out_bp(out_bp),
    .out_notch(out_notch), .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  typedef struct { longint lp; longint hp; longint bp; longint no; longint inq; } exp_t;
  exp_t   exp_q[$];
  exp_t   cur;
  exp_t   last = '{default: 0};
  int     err_cnt = 0;
  int     chk_cnt = 0;
  int     cyc = 0;
  int     txn = 0;
  longint m_lo = 0, m_hi = 0, m_bp = 0, m_f = 0, m_q1 = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint f_coef(input int v);
    real fc;
    fc = 440.0 * (2.0 ** ((real'(v) - 69.0) / 12.0));
    return longint'($rtoi(2.0 * $sin(3.141592653589793 * fc / 44100.0) * 65536.0 + 0.5));
  endfunction

  function automatic longint q1_coef(input int v);
    return longint'(131071 - 960 * v);
  endfunction

  function automatic longint fit(input longint x, input int bits);
    longint m;
    longint r;
    m = longint'(1) << bits;
`ifdef SVF_SATURATE_EN
    r = x;
    if (r > m / 2 - 1) r = m / 2 - 1;
    if (r < -(m / 2))  r = -(m / 2);
`else
    r = x & (m - 1);
    if (r >= m / 2) r = r - m;
`endif
    return r;
  endfunction

  function automatic longint sel_mux(input logic [3:0] s, input exp_t e);
    if (s == 4'd0)       return e.inq;
    else if (s <= 4'd4)  return e.lp;
    else if (s <= 4'd8)  return e.hp;
    else if (s <= 4'd12) return e.bp;
    return e.no;
  endfunction

  task automatic model_step();
    longint lo, hi, bp;
    exp_t   e;
    lo = fit(m_lo + ((m_f * m_bp) >>> 16), SW);
    hi = fit(longint'(in_s) - lo - ((m_q1 * m_bp) >>> 16), SW);
    bp = fit(m_bp + ((m_f * hi) >>> 16), SW);
    m_lo = lo;
    m_hi = hi;
    m_bp = bp;
    m_f  = f_coef(int'(freq));
    m_q1 = q1_coef(int'(q));
    e.lp  = fit(lo, SB);
    e.hp  = fit(hi, SB);
    e.bp  = fit(bp, SB);
    e.no  = fit(hi + lo, SB);
    e.inq = longint'(in_s);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_lo = 0; m_hi = 0; m_bp = 0;
      m_f  = f_coef(0);
      m_q1 = q1_coef(0);
      last = '{default: 0};
      cyc  = 0;
    end else begin
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check_val("lp", out_lp, cur.lp);
        check_val("hp", out_hp, cur.hp);
        check_val("bp", out_bp, cur.bp);
        check_val("notch", out_notch, cur.no);
        check_val("audio", audio_out, sel_mux(sel, cur));
        txn++;
        $display("txn %0d: in=%0d sel=%0d lp=%0d hp=%0d bp=%0d notch=%0d audio=%0d",
                 txn, cur.inq, sel, out_lp, out_hp, out_bp, out_notch, audio_out);
        last = cur;
      end
      cyc++;
      if (sample_stb) begin
        check_val("stb_period", cyc, DIV);
        check_val("hold_lp", out_lp, last.lp);
        check_val("hold_audio", audio_out, sel_mux(sel, last));
        cyc = 0;
        model_step();
      end
    end
  end

  task automatic wait_stb();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_stb && n < 2 * DIV);
    check_val("stb_seen", longint'(sample_stb), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_lp"}, out_lp, 0);
    check_val({tag, "_hp"}, out_hp, 0);
    check_val({tag, "_bp"}, out_bp, 0);
    check_val({tag, "_notch"}, out_notch, 0);
    check_val({tag, "_audio"}, audio_out, 0);
    check_val({tag, "_stb"}, longint'(sample_stb), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint d;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    check_val("rst_f", dut.f_q, 76);
    check_val("rst_q1", dut.q1_q, 131071);
    rst = 1'b0;

    // Free-run: first strobe at cycle DIVISOR, all-zero outputs.
    wait_stb();

    // Bypass path and hold across a mid-sample input change.
    sel  = 4'd0;
    in_s = 12'sd1000;
    wait_stb();
    check_val("byp", audio_out, 1000);
    in_s = -12'sd500;
    repeat (100) @(posedge clk);
    #1;
    check_val("byp_hold", audio_out, 1000);
    wait_stb();
    check_val("byp_next", audio_out, -500);

    // DC settling with a stable, heavily damped setting.
    freq = 7'd110;
    q    = 7'd0;
    in_s = 12'sd1000;
    sel  = 4'd1;
    repeat (40) wait_stb();
    d = longint'(out_lp) - 1000;
    check_val("dc_lp", (d >= -3 && d <= 3) ? 1000 : longint'(out_lp), 1000);
    d = longint'(out_hp);
    check_val("dc_hp", (d >= -3 && d <= 3) ? 0 : longint'(out_hp), 0);

    // sel switches between strobes take effect at once.
    @(negedge clk);
    #1;
    sel = 4'd5;
    #1 check_val("sel_hp", audio_out, last.hp);
    sel = 4'd9;
    #1 check_val("sel_bp", audio_out, last.bp);
    sel = 4'd13;
    #1 check_val("sel_notch", audio_out, last.no);
    sel = 4'd0;
    #1 check_val("sel_byp", audio_out, last.inq);
    sel = 4'd1;

    // Coefficient registers load on the strobe.
    @(posedge clk);
    #1;
    freq = 7'd69;
    q    = 7'd127;
    wait_stb();
    check_val("coef_f", dut.f_q, 4108);
    check_val("coef_q1", dut.q1_q, 9151);

    // Resonant setting driven with full-scale steps.
    freq = 7'd100;
    q    = 7'd127;
    for (int k = 0; k < 4; k++) begin
      in_s = (k % 2 == 0) ? 12'sd2047 : -12'sd2047;
      repeat (10) wait_stb();
    end

    // Reset mid-sample clears everything at once and restarts the count.
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    check_val("mid_rst_f", dut.f_q, 76);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_stb();
    wait_stb();
    repeat (3) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
